result_collector: RTL and testbench

Downstream capture stage for the compute block. Samples every 32-bit result qualified by the compute block's `valid_out`/`data_out` pair into a small show-ahead FIFO, then releases results to a consumer over a valid/ready handshake. Sticky overflow reporting covers results that arrive while the FIFO is full. Optional running statistics (count, min, max, sum) support bring-up and benchmarking.

---
 rtl/result_collector.sv | 210 +++++++++++++++++++++
 tb/tb_result_collector.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// -----------------------------------------------------------------------------
// result_collector
//
// Capture stage behind the compute block. Every result strobed on valid_in is
// written into a small show-ahead FIFO and released to a consumer over a
// valid/ready handshake. Results that arrive while the FIFO is full and no pop
// is happening are dropped and flagged on a sticky overflow bit. Optional
// running statistics (count, unsigned min/max, sum) describe the whole producer
// stream, including dropped words.
//
// Optional feature macro: RESULT_COLLECTOR_STATS_EN
//   defined     -> statistics registers and update logic are built
//   not defined -> sample_cnt_o/max_o/sum_o tied to 0, min_o tied to all-ones
//
// Parameters:
//   WIDTH         result data width
//   DEPTH         FIFO entries, power of two, >= 2
//
// Ports:
//   clk_i         clock, rising edge
//   rstn_i        asynchronous active-low reset
//   valid_in      result strobe from the compute block
//   data_in       result word from the compute block
//   clear_i       synchronous flush of FIFO, overflow flag and statistics
//   ready_in      consumer accepts data_out this cycle
//   valid_out     FIFO non-empty, data_out is valid
//   data_out      oldest stored result (show-ahead), 0 while empty
//   level_o       occupancy 0..DEPTH
//   full_o        level_o == DEPTH
//   overflow_o    sticky: a result was dropped
//   sample_cnt_o  number of results seen on valid_in (wraps at 2^16)
//   min_o         unsigned minimum of results seen
//   max_o         unsigned maximum of results seen
//   sum_o         sum of results seen (wraps at 2^(WIDTH+16))
// -----------------------------------------------------------------------------
module result_collector #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     valid_in,
   input  logic [WIDTH-1:0]         data_in,
   input  logic                     clear_i,
   input  logic                     ready_in,
   output logic                     valid_out,
   output logic [WIDTH-1:0]         data_out,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     overflow_o,
   output logic [15:0]              sample_cnt_o,
   output logic [WIDTH-1:0]         min_o,
   output logic [WIDTH-1:0]         max_o,
   output logic [WIDTH+15:0]        sum_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   // Occupancy state; valid_out and full_o are decoded straight from it.
   typedef enum logic [1:0] {
      OCC_EMPTY,
      OCC_PARTIAL,
      OCC_FULL
   } occ_t;

   occ_t             occ_q;
   occ_t             occ_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic [LW-1:0]    level_nxt;
   logic             ovf_q;
   logic             do_pop;
   logic             do_push;
   logic             do_drop;

   // -------------------------------------------------------------------------
   // Handshake decode. clear_i wins over everything in its cycle. A push into
   // a full FIFO is allowed when a pop frees the head slot in the same cycle.
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      do_pop    = 1'b0;
      do_push   = 1'b0;
      do_drop   = 1'b0;
      level_nxt = level_q;
      occ_nxt   = OCC_PARTIAL;

      if (!clear_i) begin
         do_pop  = (occ_q != OCC_EMPTY) && ready_in;
         do_push = valid_in && ((occ_q != OCC_FULL) || do_pop);
         do_drop = valid_in && !do_push;
      end

      if (clear_i) begin
         level_nxt = '0;
      end else if (do_push && !do_pop) begin
         level_nxt = level_q + LW'(1);
      end else if (do_pop && !do_push) begin
         level_nxt = level_q - LW'(1);
      end

      if (level_nxt == '0) begin
         occ_nxt = OCC_EMPTY;
      end else if (level_nxt == LW'(DEPTH)) begin
         occ_nxt = OCC_FULL;
      end
   end

   // -------------------------------------------------------------------------
   // Control state: occupancy, pointers, sticky overflow.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rstn_i) begin
      // NOTE: sequential state is written with non-blocking assignments so
      // every register samples the values from before the edge.
      if (!rstn_i) begin
         occ_q    <= OCC_EMPTY;
         level_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         occ_q   <= occ_nxt;
         level_q <= level_nxt;
         if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
         end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) begin
               wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
               rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_drop) begin
               ovf_q <= 1'b1;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Storage array.
   // -------------------------------------------------------------------------
   // NOTE: the data array is deliberately not reset; stale contents are never
   // observable because data_out is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   // Show-ahead head. The slot under rd_ptr_q is never rewritten while it is
   // the valid head (a push into that slot needs an empty FIFO, or a full one
   // with a pop moving the head away), so data_out holds while stalled.
   assign valid_out  = (occ_q != OCC_EMPTY);
   assign full_o     = (occ_q == OCC_FULL);
   assign data_out   = valid_out ? mem[rd_ptr_q] : '0;
   assign level_o    = level_q;
   assign overflow_o = ovf_q;

   // -------------------------------------------------------------------------
   // Running statistics over the producer stream (includes dropped words).
   // -------------------------------------------------------------------------
`ifdef RESULT_COLLECTOR_STATS_EN
   logic [15:0]       cnt_q;
   logic [WIDTH-1:0]  min_q;
   logic [WIDTH-1:0]  max_q;
   logic [WIDTH+15:0] sum_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
         min_q <= '1;
         max_q <= '0;
         sum_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
         min_q <= '1;
         max_q <= '0;
         sum_q <= '0;
      end else if (valid_in) begin
         cnt_q <= cnt_q + 16'd1;
         sum_q <= sum_q + {16'd0, data_in};
         if (data_in < min_q) begin
            min_q <= data_in;
         end
         if (data_in > max_q) begin
            max_q <= data_in;
         end
      end
   end

   assign sample_cnt_o = cnt_q;
   assign min_o        = min_q;
   assign max_o        = max_q;
   assign sum_o        = sum_q;
`else
   assign sample_cnt_o = '0;
   assign min_o        = '1;
   assign max_o        = '0;
   assign sum_o        = '0;
`endif

endmodule

// File: tb/tb_result_collector.sv
// -----------------------------------------------------------------------------
// tb_result_collector
//
// Self-checking bench for result_collector. A queue scoreboard models the
// FIFO: accepted pushes are appended, and on every cycle the DUT head
// (valid_out/data_out) is compared against the queue front before the edge.
// Each scenario task adds its own explicit checks of level, flags and stats.
// Statistics expectations follow RESULT_COLLECTOR_STATS_EN.
// -----------------------------------------------------------------------------
module tb_result_collector;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic               clk_i;
   logic               rstn_i;
   logic               valid_in;
   logic [WIDTH-1:0]   data_in;
   logic               clear_i;
   logic               ready_in;
   logic               valid_out;
   logic [WIDTH-1:0]   data_out;
   logic [LW-1:0]      level_o;
   logic               full_o;
   logic               overflow_o;
   logic [15:0]        sample_cnt_o;
   logic [WIDTH-1:0]   min_o;
   logic [WIDTH-1:0]   max_o;
   logic [WIDTH+15:0]  sum_o;

   int tests_run    = 0;
   int tests_failed = 0;

   // Scoreboard and reference model state.
   logic [WIDTH-1:0]  sb_q[$];
   logic              m_ovf;
   logic [15:0]       m_cnt;
   logic [WIDTH-1:0]  m_min;
   logic [WIDTH-1:0]  m_max;
   logic [WIDTH+15:0] m_sum;

   result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .valid_in     (valid_in),
      .data_in      (data_in),
      .clear_i      (clear_i),
      .ready_in     (ready_in),
      .valid_out    (valid_out),
      .data_out     (data_out),
      .level_o      (level_o),
      .full_o       (full_o),
      .overflow_o   (overflow_o),
      .sample_cnt_o (sample_cnt_o),
      .min_o        (min_o),
      .max_o        (max_o),
      .sum_o        (sum_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Expected statistics outputs: model values when built, tie-offs otherwise.
   function automatic logic [15:0] exp_cnt();
`ifdef RESULT_COLLECTOR_STATS_EN
      return m_cnt;
`else
      return 16'd0;
`endif
   endfunction

   function automatic logic [WIDTH-1:0] exp_min();
`ifdef RESULT_COLLECTOR_STATS_EN
      return m_min;
`else
      return '1;
`endif
   endfunction

   function automatic logic [WIDTH-1:0] exp_max();
`ifdef RESULT_COLLECTOR_STATS_EN
      return m_max;
`else
      return '0;
`endif
   endfunction

   function automatic logic [WIDTH+15:0] exp_sum();
`ifdef RESULT_COLLECTOR_STATS_EN
      return m_sum;
`else
      return '0;
`endif
   endfunction

   task automatic model_reset();
      sb_q.delete();
      m_ovf = 1'b0;
      m_cnt = '0;
      m_min = '1;
      m_max = '0;
      m_sum = '0;
   endtask

   // Apply a synchronous-looking reset pulse; leaves time just after a negedge.
   task automatic do_reset();
      valid_in = 1'b0;
      data_in  = '0;
      clear_i  = 1'b0;
      ready_in = 1'b0;
      rstn_i   = 1'b0;
      repeat (2) @(negedge clk_i);
      model_reset();
      rstn_i = 1'b1;
      @(negedge clk_i);
   endtask

   // One clock of stimulus. Called right after a negedge; returns right after
   // the next negedge. Checks the DUT head against the scoreboard front.
   task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] d,
                              input logic r, input logic c);
      logic             pop;
      logic             push;
      logic [WIDTH-1:0] popped;
      valid_in = v;
      data_in  = d;
      ready_in = r;
      clear_i  = c;
      #1;
      tests_run++;
      if (sb_q.size() == 0) begin
         if (valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL sb_empty_valid: valid_out=%b expected 0", valid_out);
         end
      end else begin
         if (valid_out !== 1'b1 || data_out !== sb_q[0]) begin
            tests_failed++;
            $display("FAIL sb_head: valid_out=%b data_out=%0d expected valid 1 data %0d",
                     valid_out, data_out, sb_q[0]);
         end
      end
      pop  = !c && r && (sb_q.size() > 0);
      push = !c && v && ((sb_q.size() < DEPTH) || pop);
      @(posedge clk_i);
      if (c) begin
         model_reset();
      end else begin
         if (pop) begin
            popped = sb_q.pop_front();
         end
         if (push) begin
            sb_q.push_back(d);
         end
         if (v && !push) begin
            m_ovf = 1'b1;
         end
         if (v) begin
            m_cnt = m_cnt + 16'd1;
            m_sum = m_sum + {16'd0, d};
            if (d < m_min) m_min = d;
            if (d > m_max) m_max = d;
         end
      end
      @(negedge clk_i);
      valid_in = 1'b0;
      ready_in = 1'b0;
      clear_i  = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) begin
         drive_cycle(1'b0, '0, 1'b1, 1'b0);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      rstn_i   = 1'b0;
      valid_in = 1'b0;
      data_in  = '0;
      clear_i  = 1'b0;
      ready_in = 1'b0;
      model_reset();
      #1;
      tests_run++;
      if (valid_out !== 1'b0 || data_out !== '0 || level_o !== '0 ||
          full_o !== 1'b0 || overflow_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_fifo: valid=%b data=%0d level=%0d full=%b ovf=%b expected 0 0 0 0 0",
                  valid_out, data_out, level_o, full_o, overflow_o);
      end
      tests_run++;
      if (sample_cnt_o !== 16'd0 || min_o !== {WIDTH{1'b1}} || max_o !== '0 || sum_o !== '0) begin
         tests_failed++;
         $display("FAIL reset_stats: cnt=%0d min=%h max=%h sum=%h expected 0 ffffffff 0 0",
                  sample_cnt_o, min_o, max_o, sum_o);
      end
      do_reset();
   endtask

   task automatic test_basic_order();
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         drive_cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
      end
      tests_run++;
      if (level_o !== LW'(3) || data_out !== 32'd1) begin
         tests_failed++;
         $display("FAIL basic_level3: level=%0d data_out=%0d expected 3 and 1", level_o, data_out);
      end
      drain();
      tests_run++;
      if (valid_out !== 1'b0 || level_o !== '0) begin
         tests_failed++;
         $display("FAIL basic_drained: valid=%b level=%0d expected 0 0", valid_out, level_o);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b1, WIDTH'(100 + i), 1'b0, 1'b0);
      end
      tests_run++;
      if (full_o !== 1'b1 || level_o !== LW'(DEPTH)) begin
         tests_failed++;
         $display("FAIL ovf_full: full=%b level=%0d expected 1 %0d", full_o, level_o, DEPTH);
      end
      tests_run++;
      if (overflow_o !== m_ovf || overflow_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_flag: overflow=%b expected 1", overflow_o);
      end
      tests_run++;
      if (sample_cnt_o !== exp_cnt()) begin
         tests_failed++;
         $display("FAIL ovf_count: sample_cnt=%0d expected %0d", sample_cnt_o, exp_cnt());
      end
      drain();
      tests_run++;
      if (overflow_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_sticky: overflow=%b expected 1 after drain", overflow_o);
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         drive_cycle(1'b1, WIDTH'(300 + i), 1'b0, 1'b0);
      end
      drive_cycle(1'b1, 32'd200, 1'b1, 1'b0);
      tests_run++;
      if (level_o !== LW'(DEPTH) || full_o !== 1'b1 || overflow_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_pushpop: level=%0d full=%b ovf=%b expected %0d 1 0",
                  level_o, full_o, overflow_o, DEPTH);
      end
      drain();
      // Single stored entry: simultaneous push and pop keeps level at 1.
      drive_cycle(1'b1, 32'd77, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'd78, 1'b1, 1'b0);
      tests_run++;
      if (level_o !== LW'(1) || data_out !== 32'd78) begin
         tests_failed++;
         $display("FAIL one_pushpop: level=%0d data_out=%0d expected 1 78", level_o, data_out);
      end
      // Sustained streaming: push and pop every cycle.
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1'b1, WIDTH'($urandom), 1'b1, 1'b0);
      end
      drain();
   endtask

   task automatic test_stats();
      logic [WIDTH+15:0] want_sum;
      logic [WIDTH-1:0]  want_min;
      logic [WIDTH-1:0]  want_max;
      do_reset();
      drive_cycle(1'b1, 32'd5, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'd7, 1'b0, 1'b0);
`ifdef RESULT_COLLECTOR_STATS_EN
      want_sum = 48'h1_0000_000B;
      want_min = 32'd5;
      want_max = 32'hFFFF_FFFF;
`else
      want_sum = '0;
      want_min = '1;
      want_max = '0;
`endif
      tests_run++;
      if (min_o !== want_min || min_o !== exp_min()) begin
         tests_failed++;
         $display("FAIL stats_min: min=%h expected %h", min_o, want_min);
      end
      tests_run++;
      if (max_o !== want_max || max_o !== exp_max()) begin
         tests_failed++;
         $display("FAIL stats_max: max=%h expected %h", max_o, want_max);
      end
      tests_run++;
      if (sum_o !== want_sum || sum_o !== exp_sum()) begin
         tests_failed++;
         $display("FAIL stats_sum: sum=%h expected %h", sum_o, want_sum);
      end
      tests_run++;
      if (sample_cnt_o !== exp_cnt()) begin
         tests_failed++;
         $display("FAIL stats_cnt: cnt=%0d expected %0d", sample_cnt_o, exp_cnt());
      end
      drain();
   endtask

   task automatic test_clear();
      do_reset();
      for (int i = 0; i < DEPTH + 1; i++) begin
         drive_cycle(1'b1, WIDTH'(500 + i), 1'b0, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b0, '0, 1'b1, 1'b0);
      end
      tests_run++;
      if (level_o !== LW'(4) || overflow_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL clear_setup: level=%0d ovf=%b expected 4 1", level_o, overflow_o);
      end
      drive_cycle(1'b1, 32'd42, 1'b0, 1'b1);
      tests_run++;
      if (level_o !== '0 || overflow_o !== 1'b0 || valid_out !== 1'b0 || full_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL clear_fifo: level=%0d ovf=%b valid=%b full=%b expected 0 0 0 0",
                  level_o, overflow_o, valid_out, full_o);
      end
      tests_run++;
      if (sample_cnt_o !== 16'd0 || min_o !== {WIDTH{1'b1}} || max_o !== '0 || sum_o !== '0) begin
         tests_failed++;
         $display("FAIL clear_stats: cnt=%0d min=%h max=%h sum=%h expected 0 ffffffff 0 0",
                  sample_cnt_o, min_o, max_o, sum_o);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, WIDTH'(900 + i), 1'b0, 1'b0);
      end
      #2;
      rstn_i = 1'b0;
      #1;
      tests_run++;
      if (valid_out !== 1'b0 || data_out !== '0 || level_o !== '0 ||
          full_o !== 1'b0 || overflow_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_fifo: valid=%b data=%0d level=%0d full=%b ovf=%b expected 0 0 0 0 0",
                  valid_out, data_out, level_o, full_o, overflow_o);
      end
      tests_run++;
      if (sample_cnt_o !== 16'd0 || min_o !== {WIDTH{1'b1}} || max_o !== '0 || sum_o !== '0) begin
         tests_failed++;
         $display("FAIL async_stats: cnt=%0d min=%h max=%h sum=%h expected 0 ffffffff 0 0",
                  sample_cnt_o, min_o, max_o, sum_o);
      end
      model_reset();
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);
      drive_cycle(1'b1, 32'd55, 1'b0, 1'b0);
      tests_run++;
      if (valid_out !== 1'b1 || data_out !== 32'd55 || level_o !== LW'(1)) begin
         tests_failed++;
         $display("FAIL async_first_push: valid=%b data=%0d level=%0d expected 1 55 1",
                  valid_out, data_out, level_o);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_basic_order();
      test_overflow();
      test_full_push_pop();
      test_stats();
      test_clear();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
